// File: rtl/traffic_timer.sv
// Interval timer for the highway/farm-road light controller: prescaled tick, saturating
// elapsed counter, and short/long expiry flags. Define TRAFFIC_TIMER_CFG_EN to add runtime thresholds.
module traffic_timer #(
  parameter int CLK_DIV     = 4,
  parameter int SHORT_TICKS = 3,
  parameter int LONG_TICKS  = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st,
`ifdef TRAFFIC_TIMER_CFG_EN
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_short,
  input  logic [CNT_W-1:0] cfg_long,
  output logic             cfg_err,
`endif
  output logic             ts,
  output logic             tl,
  output logic             tick,
  output logic [CNT_W-1:0] elapsed
);

  localparam int               PS_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SHORT_DEF = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] LONG_DEF  = CNT_W'(LONG_TICKS);

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] short_thr, long_thr;

  assign tick = (presc_q == PS_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    presc_d   = presc_q + PS_W'(1);
    elapsed_d = elapsed_q;
    if (st) begin
      // Restart wins over a coincident tick; that tick is simply dropped.
      presc_d   = '0;
      elapsed_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (elapsed_q != CNT_MAX) elapsed_d = elapsed_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      elapsed_q <= '0;
    end else begin
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
    end
  end

`ifdef TRAFFIC_TIMER_CFG_EN
  logic [CNT_W-1:0] short_thr_q, long_thr_q;
  logic             cfg_err_q;
  logic             cfg_valid;

  assign cfg_valid = (cfg_short != '0) && (cfg_long > cfg_short);

  // A write never touches the counter, so the flags can move as soon as thresholds change.
  always_ff @(posedge clk) begin
    if (reset) begin
      short_thr_q <= SHORT_DEF;
      long_thr_q  <= LONG_DEF;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_valid;
      if (cfg_we && cfg_valid) begin
        short_thr_q <= cfg_short;
        long_thr_q  <= cfg_long;
      end
    end
  end

  assign short_thr = short_thr_q;
  assign long_thr  = long_thr_q;
  assign cfg_err   = cfg_err_q;
`else
  assign short_thr = SHORT_DEF;
  assign long_thr  = LONG_DEF;
`endif

  // Flags decode only registered state, so there is no loop through the controller's st logic.
  assign ts      = (elapsed_q >= short_thr);
  assign tl      = (elapsed_q >= long_thr);
  assign elapsed = elapsed_q;

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Interval timer that directly serves the highway/farm-road traffic-light controller.
- Consumes the controller's start-timer pulse (st) and produces the short-interval (ts) and long-interval (tl) expiry flags the controller uses to sequence its states.
- Contains a clock prescaler and a saturating elapsed-tick counter.
- ts/tl are decoded from registered state only, so there is no combinational loop with the controller's st logic.

Parameters:
- CLK_DIV, 4, clk cycles per timer tick; legal range >=1.
- SHORT_TICKS, 3, ticks until ts asserts (yellow duration); >=1.
- LONG_TICKS, 8, ticks until tl asserts (minimum green duration); must be > SHORT_TICKS.
- CNT_W, 8, width of the elapsed counter; 2**CNT_W-1 must be >= LONG_TICKS.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- st  input  1  start/restart timer; single-cycle pulse from the controller; may be held.
- ts  output  1  short interval elapsed: elapsed >= short threshold.
- tl  output  1  long interval elapsed: elapsed >= long threshold.
- tick  output  1  one-cycle pulse, high in the cycle the prescaler is at CLK_DIV-1.
- elapsed  output  CNT_W  ticks since the last st or reset; saturating.

Behaviour:
- Reset: prescaler=0, elapsed=0, tick=0, ts=0, tl=0.
- Prescaler: a ceil(log2(CLK_DIV)) register, minimum width 1.
  - Increments each cycle and wraps from CLK_DIV-1 to 0.
  - tick = (prescaler == CLK_DIV-1), combinational from the register.
  - When CLK_DIV=1, tick is high every cycle.
- Elapsed counter: on an edge where tick=1 and st=0, elapsed increments by 1.
  - Saturates at 2**CNT_W-1 and never wraps.
- st sampled high at edge N: prescaler and elapsed are both cleared at edge N.
  - st has priority over a coincident tick; the tick is discarded.
  - st held high keeps both registers cleared every cycle, so ts and tl stay 0.
- ts and tl are combinational compares of the registered elapsed value against the thresholds. They are level signals and remain high until the next st or reset.
- Timing with defaults, for st sampled at edge N:
  - Ticks occur in the cycles before edges N+4, N+8, ...
  - elapsed=k from edge N+4k.
  - ts rises at edge N+12; tl rises at edge N+32.
- General latency: ts rises CLK_DIV*SHORT_TICKS cycles after the st edge; tl rises CLK_DIV*LONG_TICKS cycles after it.
- With no st ever issued after reset, the timer free-runs from reset exactly as if st had been sampled at the reset edge.
- Reset mid-interval: identical to st, and additionally clears the optional config registers to their defaults.

Optional Feature:
- Macro: TRAFFIC_TIMER_CFG_EN.
- Enabled: adds the following ports:
  - cfg_we input 1.
  - cfg_short input CNT_W.
  - cfg_long input CNT_W.
  - cfg_err output 1.
- Enabled, threshold registers: short_thr and long_thr reset to SHORT_TICKS and LONG_TICKS.
- Enabled, valid write: cfg_we=1 with cfg_short>=1 and cfg_long>cfg_short loads both registers at that edge; the new values apply to the compares from the next cycle.
- Enabled, rejected write: registers are unchanged and cfg_err pulses high for exactly one cycle after the edge. cfg_err resets to 0.
- Enabled, write does not restart the timer: ts/tl may change immediately if elapsed already crosses a new threshold.
- Enabled, cfg_we and st in the same cycle: both take effect.
- Disabled: thresholds are the constant parameters and the cfg ports do not exist.

Test Plan:
- Reset then defaults, st pulse at edge 2 -> elapsed=1 at edge 6; ts=1 from edge 14; tl=1 from edge 34; tick pulses every 4th cycle.
- st asserted in a cycle where tick=1 (elapsed=5) -> at that edge elapsed=0, prescaler=0, no increment; ts and tl drop to 0 the next cycle.
- st held high for 10 cycles -> elapsed stays 0, ts=tl=0 throughout; ts rises 12 cycles after st is released (12 cycles after the last edge where st=1).
- CLK_DIV=1, CNT_W=4, no st for 20 cycles after reset -> elapsed saturates at 15 and stays; tick is high every cycle; ts=tl=1.
- Reset asserted at elapsed=6 -> the next cycle gives elapsed=0, ts=tl=0, tick=0; counting resumes after release.
- TRAFFIC_TIMER_CFG_EN, two writes:
  - cfg_short=2, cfg_long=5 -> ts at 8 cycles and tl at 20 cycles after st.
  - Then cfg_short=5, cfg_long=5 -> cfg_err pulses one cycle and the thresholds stay 2/5.
